multicycle_control_unit: RTL
============================

Name: multicycle_control_unit

Overview:
- Sequential successor to the single-cycle opcode decoder: a Moore FSM that sequences a multi-cycle RV32I datapath through fetch, decode, execute, memory and writeback.
- Talks to a shared instruction/data memory over a valid/ready request + response-valid handshake, and bounds every memory wait with a timeout.
- Raises traps for illegal opcodes, ECALL/EBREAK and bus timeouts, and counts retired instructions.
- Sits between the instruction register / branch comparator and the datapath mux and write-enable controls.

Parameters:
- MEM_TIMEOUT, 16, cycles waited for mem_req_ready or mem_rsp_valid before a bus-timeout trap; must be ≥1.
- TRAP_HALT, 0, 1 = enter HALT after any trap; 0 = redirect to the trap vector and continue.
- CNT_W, 32, width of instret_count.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- instr  in  32  current instruction register contents.
- branch_taken  in  1  branch comparator result, valid in EXECUTE.
- mem_req_ready  in  1  memory accepts request.
- mem_rsp_valid  in  1  read data / write ack returned.
- mem_req_valid  out  1  memory request.
- mem_req_write  out  1  1 = store request.
- mem_addr_sel  out  1  0 = PC, 1 = ALU result.
- ir_write  out  1  latch instr and old_pc.
- pc_write  out  1  PC update strobe.
- pc_src  out  2  00 = PC+4, 01 = PC-relative target, 10 = ALU result (JALR), 11 = trap vector.
- alu_op_type  out  2  00 = add, 01 = branch compare, 10 = funct-decoded.
- alu_src_a  out  2  00 = rs1, 01 = old_pc, 10 = zero.
- alu_src_b  out  1  1 = immediate.
- wb_sel  out  2  00 = ALU, 01 = memory, 10 = old_pc+4.
- reg_write_en  out  1  register-file write.
- trap  out  1  one-cycle trap pulse.
- trap_cause  out  2  01 = illegal, 10 = bus timeout, 11 = ECALL/EBREAK; held until the next trap or reset.
- halted  out  1  FSM in HALT.
- instret_count  out  CNT_W  retired-instruction counter.

Behaviour:
- Reset values: state = FETCH. Every strobe output 0; pc_src, wb_sel, alu_src_a, alu_op_type = 00; trap_cause = 00; instret_count = 0; timeout counter = 0.
- Reset during any state, including a pending memory request, aborts it and drops mem_req_valid on the next cycle.
- Outputs are combinational from state plus the opcode class registered in DECODE.
- FETCH:
  - mem_req_valid = 1, mem_addr_sel = 0.
  - On mem_req_ready, go to FETCH_WAIT.
- FETCH_WAIT:
  - On mem_rsp_valid: ir_write = 1, pc_write = 1, pc_src = 00, go to DECODE.
- DECODE:
  - Registers the class from instr[6:0]: R, I, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, FENCE (0001111), SYSTEM (1110011).
  - Any other opcode, or SYSTEM with instr[31:7] not equal to ECALL/EBREAK encodings, goes to TRAP with cause 01.
  - SYSTEM ECALL/EBREAK goes to TRAP with cause 11.
  - FENCE retires as a NOP and goes directly to FETCH.
  - All other classes go to EXECUTE.
- EXECUTE (ALU settings by class):
  - R: alu_op_type = 10, alu_src_b = 0.
  - I: alu_op_type = 10, alu_src_b = 1.
  - LOAD/STORE: add, alu_src_b = 1.
  - LUI: alu_src_a = 10, alu_src_b = 1.
  - AUIPC: alu_src_a = 01, alu_src_b = 1.
  - BRANCH: alu_op_type = 01; if branch_taken then pc_write = 1 with pc_src = 01. Branch retires here and goes to FETCH.
  - JAL: pc_write = 1, pc_src = 01.
  - JALR: alu_src_b = 1, pc_write = 1, pc_src = 10.
  - Next state: LOAD/STORE → MEM_REQ; everything else except BRANCH → WRITEBACK.
- MEM_REQ:
  - mem_req_valid = 1, mem_addr_sel = 1, mem_req_write = STORE.
  - On mem_req_ready, go to MEM_WAIT.
- MEM_WAIT:
  - On mem_rsp_valid: LOAD → WRITEBACK; STORE retires and goes to FETCH.
- WRITEBACK:
  - reg_write_en = 1 for one cycle.
  - wb_sel = 01 for LOAD, 10 for JAL/JALR, 00 otherwise.
  - Next state FETCH (retire).
- Timeout:
  - The counter clears on entry to FETCH, FETCH_WAIT, MEM_REQ and MEM_WAIT, and increments each cycle spent waiting there.
  - When it reaches MEM_TIMEOUT without the awaited signal, go to TRAP with cause 10.
  - If ready/valid arrives in the same cycle the count hits MEM_TIMEOUT, the handshake wins.
- TRAP (one cycle):
  - trap = 1, trap_cause updated.
  - TRAP_HALT = 0: pc_write = 1, pc_src = 11, next state FETCH.
  - TRAP_HALT = 1: next state HALT.
- HALT: halted = 1, all strobes 0; exit only via rst.
- Retire: instret_count increments by 1 in the cycle that leaves a retiring state. Traps do not retire. The counter wraps modulo 2^CNT_W.
- Latencies with ready in the request cycle and rsp one cycle later:
  - Untaken or taken branch: 4 cycles.
  - R/I/LUI/AUIPC/JAL/JALR: 5 cycles.
  - Store: 6 cycles.
  - Load: 7 cycles.

Decomposition:
- Shared package `rv_ctrl_pkg` holds the opcode constants, the state encoding, the opcode-class enum, and the pc_src / wb_sel / alu_src_a / trap_cause codes.
- One sub-module: `opcode_classifier`, combinational instr → class + legality, reusing the single-cycle decode tables.

Test Plan:
- ADD 0x002081B3, zero-wait memory: sequence FETCH, FETCH_WAIT, DECODE, EXECUTE, WRITEBACK; reg_write_en = 1 exactly once, wb_sel = 00; instret_count goes 0 → 1 after 5 cycles.
- LW 0x0000A103 with mem_rsp_valid delayed 3 cycles: MEM_WAIT held 3 cycles; WRITEBACK with wb_sel = 01; no trap.
- BEQ with branch_taken = 1: pc_write pulses with pc_src = 00 in FETCH_WAIT and pc_src = 01 in EXECUTE; retires after 4 cycles.
- Opcode 0x0000007F: trap = 1 for one cycle, trap_cause = 01, pc_src = 11, instret_count unchanged.
- MEM_TIMEOUT = 4, mem_req_ready stuck low in MEM_REQ: TRAP after 4 cycles with cause 10. Repeat with TRAP_HALT = 1 → halted = 1 until rst.
- rst asserted in MEM_WAIT: next cycle is FETCH with every output at its reset value; instret_count = 0. Separately, with CNT_W = 4, 16 retirements wrap instret_count to 0.

Source files
------------

// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit:
// opcodes, FSM states, opcode classes and datapath select codes.
package rv_ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [24:0] SYS_ECALL  = 25'h0000000;
    localparam logic [24:0] SYS_EBREAK = 25'h0002000;

    typedef enum logic [3:0] {
        S_FETCH,
        S_FETCH_WAIT,
        S_DECODE,
        S_EXECUTE,
        S_MEM_REQ,
        S_MEM_WAIT,
        S_WRITEBACK,
        S_TRAP,
        S_HALT
    } state_t;

    typedef enum logic [3:0] {
        C_R, C_I, C_LOAD, C_STORE, C_BRANCH, C_JAL,
        C_JALR, C_LUI, C_AUIPC, C_FENCE, C_SYSTEM, C_ILLEGAL
    } cls_t;

    localparam logic [1:0] PC_PLUS4 = 2'b00;
    localparam logic [1:0] PC_REL   = 2'b01;
    localparam logic [1:0] PC_ALU   = 2'b10;
    localparam logic [1:0] PC_TRAP  = 2'b11;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    localparam logic [1:0] SRCA_RS1  = 2'b00;
    localparam logic [1:0] SRCA_PC   = 2'b01;
    localparam logic [1:0] SRCA_ZERO = 2'b10;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_BR    = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_BUS     = 2'b10;
    localparam logic [1:0] CAUSE_ENV     = 2'b11;

endpackage

// File: rtl/multicycle_control_unit_classifier.sv
// Combinational opcode classifier: instr -> class, legality and
// ECALL/EBREAK detection.
module opcode_classifier
    import rv_ctrl_pkg::*;
(
    input  logic [31:0] i_instr,
    output cls_t        o_cls,
    output logic        o_illegal,
    output logic        o_env
);

    logic w_sys_ok;

    assign w_sys_ok = (i_instr[31:7] == SYS_ECALL) ||
                      (i_instr[31:7] == SYS_EBREAK);

    always_comb begin
        o_cls = C_ILLEGAL;
        case (i_instr[6:0])
            OP_R:      o_cls = C_R;
            OP_I:      o_cls = C_I;
            OP_LOAD:   o_cls = C_LOAD;
            OP_STORE:  o_cls = C_STORE;
            OP_BRANCH: o_cls = C_BRANCH;
            OP_JAL:    o_cls = C_JAL;
            OP_JALR:   o_cls = C_JALR;
            OP_LUI:    o_cls = C_LUI;
            OP_AUIPC:  o_cls = C_AUIPC;
            OP_FENCE:  o_cls = C_FENCE;
            OP_SYSTEM: o_cls = C_SYSTEM;
            default:   o_cls = C_ILLEGAL;
        endcase
    end

    assign o_env     = (i_instr[6:0] == OP_SYSTEM) && w_sys_ok;
    assign o_illegal = (o_cls == C_ILLEGAL) ||
                       ((o_cls == C_SYSTEM) && !w_sys_ok);

endmodule

// File: rtl/multicycle_control_unit.sv
// Moore-style control FSM for a multi-cycle RV32I datapath with
// bounded memory waits, traps and a retired-instruction counter.
module multicycle_control_unit
    import rv_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter bit TRAP_HALT   = 1'b0,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instr,
    input  logic             branch_taken,
    input  logic             mem_req_ready,
    input  logic             mem_rsp_valid,
    output logic             mem_req_valid,
    output logic             mem_req_write,
    output logic             mem_addr_sel,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic [1:0]       alu_op_type,
    output logic [1:0]       alu_src_a,
    output logic             alu_src_b,
    output logic [1:0]       wb_sel,
    output logic             reg_write_en,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic             halted,
    output logic [CNT_W-1:0] instret_count
);

    localparam int TW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(MEM_TIMEOUT - 1);

    state_t           r_state, w_next;
    cls_t             r_cls, w_cls;
    logic             w_illegal, w_env;
    logic [TW-1:0]    r_tmo;
    logic             r_rst_q;
    logic [1:0]       r_cause, w_cause;
    logic [CNT_W-1:0] r_cnt;
    logic             w_retire, w_wait, w_hs, w_expire;

    opcode_classifier u_cls (
        .i_instr   (instr),
        .o_cls     (w_cls),
        .o_illegal (w_illegal),
        .o_env     (w_env)
    );

    // First FETCH cycle after reset stays quiet so an aborted request drops.
    always_comb begin
        w_wait = 1'b0;
        w_hs   = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_wait = !r_rst_q;
                w_hs   = !r_rst_q && mem_req_ready;
            end
            S_MEM_REQ: begin
                w_wait = 1'b1;
                w_hs   = mem_req_ready;
            end
            S_FETCH_WAIT, S_MEM_WAIT: begin
                w_wait = 1'b1;
                w_hs   = mem_rsp_valid;
            end
            default: ;
        endcase
    end

    assign w_expire = w_wait && !w_hs && (r_tmo == TMO_LAST);

    always_comb begin
        w_next        = r_state;
        w_cause       = r_cause;
        w_retire      = 1'b0;
        mem_req_valid = 1'b0;
        mem_req_write = 1'b0;
        mem_addr_sel  = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_src        = PC_PLUS4;
        alu_op_type   = ALU_ADD;
        alu_src_a     = SRCA_RS1;
        alu_src_b     = 1'b0;
        wb_sel        = WB_ALU;
        reg_write_en  = 1'b0;
        trap          = 1'b0;
        halted        = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem_req_valid = !r_rst_q;
                if (w_hs) begin
                    w_next = S_FETCH_WAIT;
                end else if (w_expire) begin
                    w_next  = S_TRAP;
                    w_cause = CAUSE_BUS;
                end
            end
            S_FETCH_WAIT: begin
                if (w_hs) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    w_next   = S_DECODE;
                end else if (w_expire) begin
                    w_next  = S_TRAP;
                    w_cause = CAUSE_BUS;
                end
            end
            S_DECODE: begin
                if (w_illegal) begin
                    w_next  = S_TRAP;
                    w_cause = CAUSE_ILLEGAL;
                end else if (w_env) begin
                    w_next  = S_TRAP;
                    w_cause = CAUSE_ENV;
                end else if (w_cls == C_FENCE) begin
                    w_next   = S_FETCH;
                    w_retire = 1'b1;
                end else begin
                    w_next = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                w_next = S_WRITEBACK;
                case (r_cls)
                    C_R: alu_op_type = ALU_FUNCT;
                    C_I: begin
                        alu_op_type = ALU_FUNCT;
                        alu_src_b   = 1'b1;
                    end
                    C_LOAD, C_STORE: begin
                        alu_src_b = 1'b1;
                        w_next    = S_MEM_REQ;
                    end
                    C_LUI: begin
                        alu_src_a = SRCA_ZERO;
                        alu_src_b = 1'b1;
                    end
                    C_AUIPC: begin
                        alu_src_a = SRCA_PC;
                        alu_src_b = 1'b1;
                    end
                    C_BRANCH: begin
                        alu_op_type = ALU_BR;
                        pc_write    = branch_taken;
                        pc_src      = branch_taken ? PC_REL : PC_PLUS4;
                        w_next      = S_FETCH;
                        w_retire    = 1'b1;
                    end
                    C_JAL: begin
                        pc_write = 1'b1;
                        pc_src   = PC_REL;
                    end
                    C_JALR: begin
                        alu_src_b = 1'b1;
                        pc_write  = 1'b1;
                        pc_src    = PC_ALU;
                    end
                    default: ;
                endcase
            end
            S_MEM_REQ: begin
                mem_req_valid = 1'b1;
                mem_addr_sel  = 1'b1;
                mem_req_write = (r_cls == C_STORE);
                if (w_hs) begin
                    w_next = S_MEM_WAIT;
                end else if (w_expire) begin
                    w_next  = S_TRAP;
                    w_cause = CAUSE_BUS;
                end
            end
            S_MEM_WAIT: begin
                if (w_hs) begin
                    if (r_cls == C_STORE) begin
                        w_next   = S_FETCH;
                        w_retire = 1'b1;
                    end else begin
                        w_next = S_WRITEBACK;
                    end
                end else if (w_expire) begin
                    w_next  = S_TRAP;
                    w_cause = CAUSE_BUS;
                end
            end
            S_WRITEBACK: begin
                reg_write_en = 1'b1;
                if (r_cls == C_LOAD) begin
                    wb_sel = WB_MEM;
                end else if (r_cls == C_JAL || r_cls == C_JALR) begin
                    wb_sel = WB_PC4;
                end
                w_next   = S_FETCH;
                w_retire = 1'b1;
            end
            S_TRAP: begin
                trap = 1'b1;
                if (TRAP_HALT) begin
                    w_next = S_HALT;
                end else begin
                    pc_write = 1'b1;
                    pc_src   = PC_TRAP;
                    w_next   = S_FETCH;
                end
            end
            S_HALT: halted = 1'b1;
            default: w_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
            r_cls   <= C_R;
            r_tmo   <= '0;
            r_cause <= CAUSE_NONE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cause <= w_cause;
            if (r_state == S_DECODE) begin
                r_cls <= w_cls;
            end
            if (w_wait && !w_hs && !w_expire) begin
                r_tmo <= r_tmo + TW'(1);
            end else begin
                r_tmo <= '0;
            end
            if (w_retire) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        r_rst_q <= rst;
    end

    assign trap_cause    = r_cause;
    assign instret_count = r_cnt;

endmodule
